sisc_ctrl_mc: RTL

//  Parametrised multicycle control unit for the next-generation SISC core.

---
 rtl/sisc_ctrl_mc_pkg.sv | 37 +++
 rtl/sisc_ctrl_mc_if.sv | 36 +++
 rtl/sisc_ctrl_mc_mem_timer.sv | 28 ++
 rtl/sisc_ctrl_mc.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sisc_ctrl_mc_pkg.sv
// Shared definitions for the SISC multicycle control unit: opcodes, FSM states
// and ALU operation encodings.
package sisc_ctrl_mc_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_RR = 4'h1;
  localparam logic [3:0] OP_ALU_RI = 4'h2;
  localparam logic [3:0] OP_LOD    = 4'h3;
  localparam logic [3:0] OP_STR    = 4'h4;
  localparam logic [3:0] OP_BRA    = 4'h5;
  localparam logic [3:0] OP_BRR    = 4'h6;
  localparam logic [3:0] OP_BNE    = 4'h7;
  localparam logic [3:0] OP_BNR    = 4'h8;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int ALU_PASS = 0;
  localparam int ALU_RR   = 1;
  localparam int ALU_RI   = 2;
  localparam int ALU_ADDR = 3;

  typedef enum logic [2:0] {
    ST_START,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT,
    ST_ERROR
  } state_t;

  // Absolute-target branches take the immediate directly as the new PC.
  function automatic logic is_abs_branch(input logic [3:0] op);
    return (op == OP_BRA) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/sisc_ctrl_mc_if.sv
// Control bus between the SISC control unit (master) and its datapath (slave).
interface sisc_ctrl_mc_if #(
  parameter int ALU_OP_W = 2,
  parameter int STAT_W   = 4
);
  logic [3:0]          opcode;
  logic [STAT_W-1:0]   mm;
  logic [STAT_W-1:0]   stat;
  logic                mem_ack;
  logic                rf_we;
  logic [ALU_OP_W-1:0] alu_op;
  logic                wb_sel;
  logic                br_sel;
  logic                pc_sel;
  logic                pc_write;
  logic                pc_rst;
  logic                ir_load;
  logic                rb_sel;
  logic                stat_en;
  logic                mem_req;
  logic                mem_we;
  logic                halted;
  logic                bus_err;

  modport master (
    input  opcode, mm, stat, mem_ack,
    output rf_we, alu_op, wb_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load,
           rb_sel, stat_en, mem_req, mem_we, halted, bus_err
  );

  modport slave (
    output opcode, mm, stat, mem_ack,
    input  rf_we, alu_op, wb_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load,
           rb_sel, stat_en, mem_req, mem_we, halted, bus_err
  );
endinterface

// File: rtl/sisc_ctrl_mc_mem_timer.sv
// Memory wait-state counter: counts cycles without acknowledge and flags
// expiry once MEM_TO waits have accumulated.
module sisc_ctrl_mc_mem_timer #(
  parameter int MEM_TO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CNT_W = $clog2(MEM_TO + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(MEM_TO));

endmodule

// File: rtl/sisc_ctrl_mc.sv
// Multicycle control FSM for the SISC core: sequences fetch/decode/execute/
// memory/writeback and decodes all datapath selects from the registered state.
module sisc_ctrl_mc
  import sisc_ctrl_mc_pkg::*;
#(
  parameter int ALU_OP_W = 2,
  parameter int STAT_W   = 4,
  parameter int MEM_TO   = 15
) (
  input  logic             clk,
  input  logic             rst_f,
  sisc_ctrl_mc_if.master   bus
);

  state_t            state, state_nxt;
  logic              tmr_clr, tmr_inc, tmr_expired;
  logic [STAT_W-1:0] hits;
  logic              take;

  sisc_ctrl_mc_mem_timer #(.MEM_TO(MEM_TO)) u_timer (
    .clk     (clk),
    .rst     (rst_f),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  assign tmr_clr = (state != ST_MEM) || bus.mem_ack;
  assign tmr_inc = (state == ST_MEM) && !bus.mem_ack;

  // An empty mask yields "no hit": never taken on BRA/BRR, always on BNE/BNR.
  assign hits = bus.mm & bus.stat;
  always_comb begin
    take = 1'b0;
    case (bus.opcode)
      OP_BRA, OP_BRR: take = |hits;
      OP_BNE, OP_BNR: take = ~|hits;
      default:        take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) state <= ST_START;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_START:     state_nxt = ST_FETCH;
      ST_FETCH:     state_nxt = ST_DECODE;
      ST_DECODE:    state_nxt = (bus.opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: begin
        case (bus.opcode)
          OP_ALU_RR, OP_ALU_RI: state_nxt = ST_WRITEBACK;
          OP_LOD, OP_STR:       state_nxt = ST_MEM;
          default:              state_nxt = ST_FETCH;
        endcase
      end
      // Acknowledge has priority over a timeout expiring in the same cycle.
      ST_MEM: begin
        if (bus.mem_ack)      state_nxt = (bus.opcode == OP_LOD) ? ST_WRITEBACK : ST_FETCH;
        else if (tmr_expired) state_nxt = ST_ERROR;
      end
      ST_WRITEBACK: state_nxt = ST_FETCH;
      ST_HALT:      state_nxt = ST_HALT;
      ST_ERROR:     state_nxt = ST_ERROR;
      default:      state_nxt = ST_START;
    endcase
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.alu_op   = ALU_OP_W'(ALU_PASS);
    bus.wb_sel   = 1'b0;
    bus.br_sel   = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_rst   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.rb_sel   = 1'b0;
    bus.stat_en  = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.halted   = 1'b0;
    bus.bus_err  = 1'b0;
    case (state)
      ST_START: bus.pc_rst = 1'b1;
      ST_FETCH: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
      end
      ST_EXECUTE: begin
        case (bus.opcode)
          OP_ALU_RR: begin
            bus.alu_op  = ALU_OP_W'(ALU_RR);
            bus.stat_en = 1'b1;
          end
          OP_ALU_RI: begin
            bus.alu_op  = ALU_OP_W'(ALU_RI);
            bus.stat_en = 1'b1;
          end
          OP_LOD: bus.alu_op = ALU_OP_W'(ALU_ADDR);
          OP_STR: begin
            bus.alu_op = ALU_OP_W'(ALU_ADDR);
            bus.rb_sel = 1'b1;
          end
          OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
            bus.pc_sel   = take;
            bus.pc_write = take;
            bus.br_sel   = take && is_abs_branch(bus.opcode);
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (bus.opcode == OP_STR);
      end
      ST_WRITEBACK: begin
        bus.rf_we  = 1'b1;
        bus.wb_sel = (bus.opcode == OP_LOD);
      end
      ST_HALT:  bus.halted = 1'b1;
      ST_ERROR: begin
        bus.halted  = 1'b1;
        bus.bus_err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
